// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin burst arbiter sharing one channel between two requesters via a 2:1 mux
module MUX2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux2_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             last0,
  input  logic             last1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_n;
  logic sel_n, prio, prio_n, reqx, lastx, reqo, xfer, end_ab, done;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      sel   <= 1'b0;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      prio  <= prio_n;
      cnt   <= cnt_n;
    end
  end
  // in a G state sel already names the owner, so it indexes the current requester
  always_comb begin
    reqx    = sel ? req1 : req0;
    lastx   = sel ? last1 : last0;
    reqo    = sel ? req0 : req1;
    xfer    = out_valid && out_ready;
    cnt_inc = cnt + 1'b1;
    end_ab  = xfer && (lastx || cnt_inc == MB);
    done    = end_ab || !reqx;
    state_n = state;
    sel_n   = sel;
    prio_n  = prio;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (req0 || req1) begin
        sel_n   = (req0 && req1) ? prio : req1;
        state_n = sel_n ? G1 : G0;
        cnt_n   = '0;
      end
    end else if (done) begin
      prio_n  = ~sel;
      cnt_n   = '0;
      sel_n   = reqo ? ~sel : sel;
      state_n = reqo ? (sel ? G0 : G1) : end_ab ? state : IDLE;
    end else begin
      cnt_n = xfer ? cnt_inc : cnt;
    end
  end
  always_comb begin
    busy      = state != IDLE;
    gnt0      = state == G0;
    gnt1      = state == G1;
    out_valid = busy && (sel ? req1 : req0);
    out_last  = out_valid && (sel ? last1 : last0);
  end
  MUX2 #(.WIDTH(WIDTH)) u_mux (.a(data0), .b(data1), .s(sel), .y(out_data));
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed bursts plus random traffic against a per-cycle ownership model
module tb_mux2_arbiter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rstn, req0, req1, last0, last1, out_ready;
  logic [W-1:0] data0, data1, od0, od1;
  logic [1:0] g0, g1, sl, ov, ol, bz;
  int checks = 0, errors = 0;
  int mo[2], ms[2], mp[2], mn[2];
  int mb[2] = '{4, 1};
  int rem[2], wid[2], pend[2];
  int lcnt;
  logic [31:0] lsig;
  bit rnd;
  int rdy_q[$];

  always #5 clk = ~clk;

  mux2_arbiter #(.WIDTH(W), .MAX_BURST(4)) u4 (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .out_ready(out_ready), .gnt0(g0[0]), .gnt1(g1[0]),
    .sel(sl[0]), .out_valid(ov[0]), .out_data(od0), .out_last(ol[0]), .busy(bz[0]));

  mux2_arbiter #(.WIDTH(W), .MAX_BURST(1)) u1 (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .out_ready(out_ready), .gnt0(g0[1]), .gnt1(g1[1]),
    .sel(sl[1]), .out_valid(ov[1]), .out_data(od1), .out_last(ol[1]), .busy(bz[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected outputs follow from who owns the channel (mo: -1 none, 0, 1)
  task automatic compare();
    bit ev;
    string s;
    logic [W-1:0] d;
    for (int i = 0; i < 2; i++) begin
      s  = $sformatf("mb%0d", mb[i]);
      d  = (ms[i] == 1) ? data1 : data0;
      ev = mo[i] >= 0 && ((mo[i] == 1) ? req1 : req0);
      chk({s, "_gnt0"}, 32'(g0[i]), 32'(mo[i] == 0));
      chk({s, "_gnt1"}, 32'(g1[i]), 32'(mo[i] == 1));
      chk({s, "_sel"}, 32'(sl[i]), 32'(ms[i]));
      chk({s, "_busy"}, 32'(bz[i]), 32'(mo[i] >= 0));
      chk({s, "_valid"}, 32'(ov[i]), 32'(ev));
      chk({s, "_last"}, 32'(ol[i]), 32'(ev && ((ms[i] == 1) ? last1 : last0)));
      chk({s, "_data"}, (i == 1) ? od1 : od0, d);
    end
  endtask

  task automatic mstep(input int i);
    bit r[2];
    bit l[2];
    bit x;
    int o;
    r[0] = req0; r[1] = req1; l[0] = last0; l[1] = last1;
    if (!rstn) begin
      mo[i] = -1; ms[i] = 0; mp[i] = 0; mn[i] = 0;
    end else if (mo[i] < 0) begin
      if (r[0] || r[1]) begin
        o = (r[0] && r[1]) ? mp[i] : int'(r[1]);
        mo[i] = o; ms[i] = o; mn[i] = 0;
      end
    end else begin
      o = mo[i];
      x = r[o] && out_ready;
      if (x) mn[i]++;
      if ((x && (l[o] || mn[i] == mb[i])) || !r[o]) begin
        mp[i] = 1 - o;
        mn[i] = 0;
        if (r[1-o]) begin
          mo[i] = 1 - o; ms[i] = 1 - o;
        end else if (!x) mo[i] = -1;
      end
    end
  endtask

  task automatic drive_req();
    if (rnd) begin
      req0  = $urandom_range(0, 9) < 7;
      req1  = $urandom_range(0, 9) < 7;
      last0 = $urandom_range(0, 2) == 0;
      last1 = $urandom_range(0, 2) == 0;
      data0 = $urandom;
      data1 = $urandom;
    end else begin
      req0  = rem[0] > 0;
      req1  = rem[1] > 0;
      last0 = rem[0] == 1;
      last1 = rem[1] == 1;
      data0 = 32'h1000_0000 + W'(wid[0]);
      data1 = 32'h2000_0000 + W'(wid[1]);
    end
  endtask

  task automatic cyc();
    bit xf;
    int src;
    @(negedge clk);
    compare();
    src = mo[0];
    xf  = rstn && src >= 0 && ((src == 1) ? req1 : req0) && out_ready;
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
    if (xf && !rnd) begin
      rem[src]--;
      wid[src]++;
      lcnt++;
      lsig = {lsig[30:0], src[0]};
      if (rem[src] == 0 && pend[src] > 0) begin
        rem[src]  = pend[src];
        pend[src] = 0;
      end
    end
    drive_req();
    out_ready = rnd ? ($urandom_range(0, 3) != 0) : (rdy_q.size() > 0 ? rdy_q.pop_front() != 0 : 1'b1);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic add(input int i, input int n);
    if (rem[i] == 0) rem[i] = n;
    else pend[i] = n;
    drive_req();
  endtask

  task automatic start();
    rnd  = 0;
    rstn = 1'b0;
    rem  = '{0, 0};
    pend = '{0, 0};
    lcnt = 0;
    lsig = '0;
    rdy_q.delete();
    drive_req();
    out_ready = 1'b1;
    cyc();
    rstn = 1'b1;
  endtask

  task automatic order(input string tag, input int n, input logic [31:0] sig);
    chk({tag, "_count"}, 32'(lcnt), 32'(n));
    chk({tag, "_order"}, lsig, sig);
  endtask

  initial begin
    mo  = '{-1, -1};
    ms  = '{0, 0};
    mp  = '{0, 0};
    mn  = '{0, 0};
    wid = '{0, 0};
    start();
    add(0, 3);
    run(7);
    order("single3", 3, 32'b0);
    start();
    add(0, 2);
    add(1, 2);
    run(8);
    order("both2", 4, 32'b0011);
    start();
    add(0, 8);
    run(12);
    order("regrant8", 8, 32'b0);
    start();
    add(0, 8);
    run(2);
    add(1, 2);
    run(14);
    order("interleave", 10, 32'b0000110000);
    start();
    add(0, 2);
    rdy_q = '{1, 0, 0, 1};
    run(7);
    order("stall", 2, 32'b0);
    start();
    add(0, 4);
    run(3);
    rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    run(6);
    order("midreset", 4, 32'b0);
    rnd = 1;
    drive_req();
    repeat (3000) begin
      rstn = $urandom_range(0, 199) != 0;
      cyc();
    end
    rstn = 1'b1;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
